// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LS memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP
   } state_e;

   typedef enum logic {
      OWN_IF,
      OWN_LS
   } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// One transaction in flight; LS has priority unless a pending IF has been starved.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clk_ip,
   input  logic                    rst_n_ip,
   input  logic                    if_req_ip,
   input  logic [ADDR_WIDTH-1:0]   if_addr_ip,
   output logic                    if_gnt_op,
   output logic                    if_rvalid_op,
   output logic [DATA_WIDTH-1:0]   if_rdata_op,
   input  logic                    ls_req_ip,
   input  logic                    ls_we_ip,
   input  logic [DATA_WIDTH/8-1:0] ls_be_ip,
   input  logic [ADDR_WIDTH-1:0]   ls_addr_ip,
   input  logic [DATA_WIDTH-1:0]   ls_wdata_ip,
   output logic                    ls_gnt_op,
   output logic                    ls_rvalid_op,
   output logic [DATA_WIDTH-1:0]   ls_rdata_op,
   output logic                    mem_req_op,
   output logic                    mem_we_op,
   output logic [DATA_WIDTH/8-1:0] mem_be_op,
   output logic [ADDR_WIDTH-1:0]   mem_addr_op,
   output logic [DATA_WIDTH-1:0]   mem_wdata_op,
   input  logic                    mem_gnt_ip,
   input  logic                    mem_rvalid_ip,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_ip
);

   localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);

   state_e                 state_q;
   owner_e                 owner_q;
   logic [CNT_WIDTH-1:0]   starve_cnt_q;
   logic                   stale_ok_q;

   logic starve_hit;
   logic pick_ls;
   logic gnt_ev;
   logic rvalid_ev;

   // A pending IF that has lost STARVE_LIMIT times in a row blocks LS once.
   assign starve_hit = if_req_ip && (starve_cnt_q == CNT_WIDTH'(STARVE_LIMIT));
   assign pick_ls    = ls_req_ip && !starve_hit;
   assign gnt_ev     = (state_q == REQ)  && mem_gnt_ip;
   assign rvalid_ev  = (state_q == RESP) && mem_rvalid_ip;

   assign if_gnt_op    = gnt_ev    && (owner_q == OWN_IF);
   assign ls_gnt_op    = gnt_ev    && (owner_q == OWN_LS);
   assign if_rvalid_op = rvalid_ev && (owner_q == OWN_IF);
   assign ls_rvalid_op = rvalid_ev && (owner_q == OWN_LS);

   // Read data is gated so both ports read zero outside their own response cycle.
   assign if_rdata_op = if_rvalid_op ? mem_rdata_ip : '0;
   assign ls_rdata_op = ls_rvalid_op ? mem_rdata_ip : '0;

   // NOTE: all state here uses non-blocking assignments so every register samples
   // the pre-edge values; blocking would make ordering inside the block matter.
   always_ff @(posedge clk_ip or negedge rst_n_ip) begin
      if (!rst_n_ip) begin
         state_q      <= IDLE;
         owner_q      <= OWN_IF;
         starve_cnt_q <= '0;
         stale_ok_q   <= 1'b1;
         mem_req_op   <= 1'b0;
         mem_we_op    <= 1'b0;
         mem_be_op    <= '0;
         mem_addr_op  <= '0;
         mem_wdata_op <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_ls) begin
                  owner_q      <= OWN_LS;
                  mem_we_op    <= ls_we_ip;
                  mem_be_op    <= ls_be_ip;
                  mem_addr_op  <= ls_addr_ip;
                  mem_wdata_op <= ls_wdata_ip;
                  mem_req_op   <= 1'b1;
                  state_q      <= REQ;
                  // pick_ls with if_req high implies the counter is below the limit
                  if (if_req_ip) starve_cnt_q <= starve_cnt_q + CNT_WIDTH'(1);
               end else if (if_req_ip) begin
                  owner_q      <= OWN_IF;
                  mem_we_op    <= 1'b0;
                  mem_be_op    <= '1;
                  mem_addr_op  <= if_addr_ip;
                  mem_wdata_op <= '0;
                  mem_req_op   <= 1'b1;
                  state_q      <= REQ;
                  starve_cnt_q <= '0;
               end
            end
            REQ: begin
               if (mem_gnt_ip) begin
                  mem_req_op <= 1'b0;
                  stale_ok_q <= 1'b0;
                  state_q    <= RESP;
               end
            end
            RESP: begin
               if (mem_rvalid_ip) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A response left over from a transaction cut short by reset may arrive before
   // the next grant; it is dropped. Any other response outside RESP is a protocol error.
   a_rvalid_in_resp: assert property (@(posedge clk_ip) disable iff (!rst_n_ip)
      (mem_rvalid_ip && (state_q != RESP)) |-> stale_ok_q)
      else $error("mem_rvalid_ip outside RESP");

   a_req_held: assert property (@(posedge clk_ip) disable iff (!rst_n_ip)
      (state_q == REQ) |-> ((owner_q == OWN_IF) ? if_req_ip : ls_req_ip))
      else $error("owner request dropped before grant");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

   localparam logic [31:0] Z32    = 32'h0;
   localparam logic [68:0] PN     = '0;
   localparam logic [4:0]  C_NONE = 5'b00000;
   localparam logic [4:0]  C_IFG  = 5'b10000;
   localparam logic [4:0]  C_IFV  = 5'b01000;
   localparam logic [4:0]  C_LSG  = 5'b00100;
   localparam logic [4:0]  C_LSV  = 5'b00010;
   localparam logic [4:0]  C_REQ  = 5'b00001;
   // Owner of each grant with IF held high and LS back-to-back (1 = LS)
   localparam logic [5:0]  STARVE_SEQ = 6'b101111;

   logic        clk_ip = 1'b0;
   logic        rst_n_ip;
   logic        if_req_ip;
   logic [31:0] if_addr_ip;
   logic        if_gnt_op, if_rvalid_op;
   logic [31:0] if_rdata_op;
   logic        ls_req_ip, ls_we_ip;
   logic [3:0]  ls_be_ip;
   logic [31:0] ls_addr_ip, ls_wdata_ip;
   logic        ls_gnt_op, ls_rvalid_op;
   logic [31:0] ls_rdata_op;
   logic        mem_req_op, mem_we_op;
   logic [3:0]  mem_be_op;
   logic [31:0] mem_addr_op, mem_wdata_op;
   logic        mem_gnt_ip, mem_rvalid_ip;
   logic [31:0] mem_rdata_ip;

   int n_cmp  = 0;
   int n_fail = 0;

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk_ip(clk_ip), .rst_n_ip(rst_n_ip),
      .if_req_ip(if_req_ip), .if_addr_ip(if_addr_ip),
      .if_gnt_op(if_gnt_op), .if_rvalid_op(if_rvalid_op), .if_rdata_op(if_rdata_op),
      .ls_req_ip(ls_req_ip), .ls_we_ip(ls_we_ip), .ls_be_ip(ls_be_ip),
      .ls_addr_ip(ls_addr_ip), .ls_wdata_ip(ls_wdata_ip),
      .ls_gnt_op(ls_gnt_op), .ls_rvalid_op(ls_rvalid_op), .ls_rdata_op(ls_rdata_op),
      .mem_req_op(mem_req_op), .mem_we_op(mem_we_op), .mem_be_op(mem_be_op),
      .mem_addr_op(mem_addr_op), .mem_wdata_op(mem_wdata_op),
      .mem_gnt_ip(mem_gnt_ip), .mem_rvalid_ip(mem_rvalid_ip), .mem_rdata_ip(mem_rdata_ip)
   );

   always #5 clk_ip = ~clk_ip;

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        ls_req;
      logic        ls_we;
      logic [3:0]  ls_be;
      logic [31:0] ls_addr;
      logic [31:0] ls_wdata;
      logic        mem_gnt;
      logic        mem_rvalid;
      logic [31:0] mem_rdata;
      logic [4:0]  exp_ctrl;   // {if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req}
      logic [68:0] exp_pay;    // {we, be, addr, wdata}, compared while mem_req is expected
      logic [31:0] exp_rdata;  // compared on the port expected to pulse rvalid
      logic        chk_rdata;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [68:0] pay(input logic we, input logic [3:0] be,
                                        input logic [31:0] addr, input logic [31:0] wdata);
      return {we, be, addr, wdata};
   endfunction

   function automatic logic [159:0] all_out();
      return 160'({if_gnt_op, if_rvalid_op, ls_gnt_op, ls_rvalid_op, mem_req_op,
                   mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op, if_rdata_op, ls_rdata_op});
   endfunction

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_ip);
      #1;
   endtask

   task automatic add(input logic ir, input logic [31:0] ia,
                      input logic lr, input logic lw, input logic [3:0] lb,
                      input logic [31:0] la, input logic [31:0] ld,
                      input logic mg, input logic mv, input logic [31:0] md,
                      input logic [4:0] ec, input logic [68:0] ep,
                      input logic [31:0] erd, input logic chk);
      vec_t v;
      v.if_req = ir;     v.if_addr = ia;
      v.ls_req = lr;     v.ls_we = lw;     v.ls_be = lb;
      v.ls_addr = la;    v.ls_wdata = ld;
      v.mem_gnt = mg;    v.mem_rvalid = mv; v.mem_rdata = md;
      v.exp_ctrl = ec;   v.exp_pay = ep;   v.exp_rdata = erd; v.chk_rdata = chk;
      vecs.push_back(v);
   endtask

   task automatic run_rows(input string grp, input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         if_req_ip     = vecs[i].if_req;
         if_addr_ip    = vecs[i].if_addr;
         ls_req_ip     = vecs[i].ls_req;
         ls_we_ip      = vecs[i].ls_we;
         ls_be_ip      = vecs[i].ls_be;
         ls_addr_ip    = vecs[i].ls_addr;
         ls_wdata_ip   = vecs[i].ls_wdata;
         mem_gnt_ip    = vecs[i].mem_gnt;
         mem_rvalid_ip = vecs[i].mem_rvalid;
         mem_rdata_ip  = vecs[i].mem_rdata;
         #1;
         check($sformatf("%s row%0d ctrl", grp, i - lo),
               160'({if_gnt_op, if_rvalid_op, ls_gnt_op, ls_rvalid_op, mem_req_op}),
               160'(vecs[i].exp_ctrl));
         if (vecs[i].exp_ctrl[0])
            check($sformatf("%s row%0d payload", grp, i - lo),
                  160'({mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op}),
                  160'(vecs[i].exp_pay));
         if (vecs[i].chk_rdata)
            check($sformatf("%s row%0d rdata", grp, i - lo),
                  160'(vecs[i].exp_ctrl[3] ? if_rdata_op : ls_rdata_op),
                  160'(vecs[i].exp_rdata));
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int g1_lo, g1_hi, g2_lo, g2_hi, g4_lo, g4_hi, g5_lo, g5_hi, g6_lo, g6_hi;
      int lsn;
      logic exp_ls;

      // 1: single IF read of 0x100
      g1_lo = vecs.size();
      add(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b0, Z32, C_NONE, PN, Z32, 1'b0);
      add(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b1, 1'b0, Z32, C_REQ | C_IFG,
          pay(1'b0, 4'hF, 32'h100, Z32), Z32, 1'b0);
      add(1'b0, Z32, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b0, Z32, C_NONE, PN, Z32, 1'b0);
      add(1'b0, Z32, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b1, 32'hDEADBEEF, C_IFV, PN,
          32'hDEADBEEF, 1'b1);
      add(1'b0, Z32, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b0, Z32, C_NONE, PN, Z32, 1'b0);
      g1_hi = vecs.size();

      // 2: IF 0x500 and LS load 0x200 together; LS first, one IDLE cycle, then IF
      g2_lo = vecs.size();
      add(1'b1, 32'h500, 1'b1, 1'b0, 4'hF, 32'h200, Z32, 1'b0, 1'b0, Z32, C_NONE, PN, Z32, 1'b0);
      add(1'b1, 32'h500, 1'b1, 1'b0, 4'hF, 32'h200, Z32, 1'b1, 1'b0, Z32, C_REQ | C_LSG,
          pay(1'b0, 4'hF, 32'h200, Z32), Z32, 1'b0);
      add(1'b1, 32'h500, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b0, Z32, C_NONE, PN, Z32, 1'b0);
      add(1'b1, 32'h500, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b1, 32'h11112222, C_LSV, PN,
          32'h11112222, 1'b1);
      add(1'b1, 32'h500, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b0, Z32, C_NONE, PN, Z32, 1'b0);
      add(1'b1, 32'h500, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b1, 1'b0, Z32, C_REQ | C_IFG,
          pay(1'b0, 4'hF, 32'h500, Z32), Z32, 1'b0);
      add(1'b0, Z32, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b0, Z32, C_NONE, PN, Z32, 1'b0);
      add(1'b0, Z32, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b1, 32'h33334444, C_IFV, PN,
          32'h33334444, 1'b1);
      add(1'b0, Z32, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b0, Z32, C_NONE, PN, Z32, 1'b0);
      g2_hi = vecs.size();

      // 4: store be=0x3 addr 0x40 data 0x1234; response is an ack only
      g4_lo = vecs.size();
      add(1'b0, Z32, 1'b1, 1'b1, 4'h3, 32'h40, 32'h1234, 1'b0, 1'b0, Z32, C_NONE, PN, Z32, 1'b0);
      add(1'b0, Z32, 1'b1, 1'b1, 4'h3, 32'h40, 32'h1234, 1'b1, 1'b0, Z32, C_REQ | C_LSG,
          pay(1'b1, 4'h3, 32'h40, 32'h1234), Z32, 1'b0);
      add(1'b0, Z32, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b0, Z32, C_NONE, PN, Z32, 1'b0);
      add(1'b0, Z32, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b1, 32'hAAAA5555, C_LSV, PN, Z32, 1'b0);
      add(1'b0, Z32, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b0, Z32, C_NONE, PN, Z32, 1'b0);
      g4_hi = vecs.size();

      // 5: IF read 0x300 with the memory grant stalled for 5 cycles
      g5_lo = vecs.size();
      add(1'b1, 32'h300, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b0, Z32, C_NONE, PN, Z32, 1'b0);
      for (int i = 0; i < 5; i++)
         add(1'b1, 32'h300, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b0, Z32, C_REQ,
             pay(1'b0, 4'hF, 32'h300, Z32), Z32, 1'b0);
      add(1'b1, 32'h300, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b1, 1'b0, Z32, C_REQ | C_IFG,
          pay(1'b0, 4'hF, 32'h300, Z32), Z32, 1'b0);
      add(1'b0, Z32, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b0, Z32, C_NONE, PN, Z32, 1'b0);
      add(1'b0, Z32, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b1, 32'h0BADF00D, C_IFV, PN,
          32'h0BADF00D, 1'b1);
      add(1'b0, Z32, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b0, Z32, C_NONE, PN, Z32, 1'b0);
      g5_hi = vecs.size();

      // 6 (tail): normal IF read 0x900 after the mid-transaction reset
      g6_lo = vecs.size();
      add(1'b1, 32'h900, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b0, Z32, C_NONE, PN, Z32, 1'b0);
      add(1'b1, 32'h900, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b1, 1'b0, Z32, C_REQ | C_IFG,
          pay(1'b0, 4'hF, 32'h900, Z32), Z32, 1'b0);
      add(1'b0, Z32, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b0, Z32, C_NONE, PN, Z32, 1'b0);
      add(1'b0, Z32, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b1, 32'hCAFEF00D, C_IFV, PN,
          32'hCAFEF00D, 1'b1);
      add(1'b0, Z32, 1'b0, 1'b0, 4'h0, Z32, Z32, 1'b0, 1'b0, Z32, C_NONE, PN, Z32, 1'b0);
      g6_hi = vecs.size();

      // Reset: every output zero even with memory read data present
      rst_n_ip = 1'b0;
      if_req_ip = 1'b0;  if_addr_ip = Z32;
      ls_req_ip = 1'b0;  ls_we_ip = 1'b0;  ls_be_ip = 4'h0;  ls_addr_ip = Z32;  ls_wdata_ip = Z32;
      mem_gnt_ip = 1'b0; mem_rvalid_ip = 1'b0; mem_rdata_ip = 32'hFFFFFFFF;
      repeat (2) @(posedge clk_ip);
      #1;
      check("reset outputs", all_out(), 160'(0));
      rst_n_ip = 1'b1;
      mem_rdata_ip = Z32;
      tick();

      run_rows("if_read", g1_lo, g1_hi);
      run_rows("both_req", g2_lo, g2_hi);

      // 3: IF held, LS back-to-back: four LS grants, then IF, then LS again
      if_req_ip = 1'b1;  if_addr_ip = 32'h600;
      ls_req_ip = 1'b1;  ls_we_ip = 1'b0;  ls_be_ip = 4'hF;  ls_wdata_ip = Z32;
      lsn = 0;
      for (int k = 0; k < 6; k++) begin
         ls_addr_ip = 32'h700 + 32'(lsn);
         exp_ls = STARVE_SEQ[k];
         tick();
         mem_gnt_ip = 1'b1;
         #1;
         check($sformatf("starve gnt%0d", k), 160'({if_gnt_op, ls_gnt_op}), 160'({~exp_ls, exp_ls}));
         check($sformatf("starve addr%0d", k), 160'(mem_addr_op),
               160'(exp_ls ? 32'h700 + 32'(lsn) : 32'h600));
         tick();
         mem_gnt_ip = 1'b0;
         mem_rvalid_ip = 1'b1;
         mem_rdata_ip = 32'hA0 + 32'(k);
         #1;
         check($sformatf("starve rvalid%0d", k), 160'({if_rvalid_op, ls_rvalid_op}),
               160'({~exp_ls, exp_ls}));
         check($sformatf("starve rdata%0d", k), 160'(exp_ls ? ls_rdata_op : if_rdata_op),
               160'(32'hA0 + 32'(k)));
         tick();
         mem_rvalid_ip = 1'b0;
         if (exp_ls) lsn++;
      end
      if_req_ip = 1'b0;
      ls_req_ip = 1'b0;
      tick();

      run_rows("store", g4_lo, g4_hi);
      run_rows("gnt_stall", g5_lo, g5_hi);

      // 6: reset asserted while waiting for the response
      if_req_ip = 1'b1;  if_addr_ip = 32'h800;
      tick();
      mem_gnt_ip = 1'b1;
      #1;
      check("rst_seq gnt", 160'({if_gnt_op, ls_gnt_op, mem_req_op}), 160'(3'b101));
      tick();
      mem_gnt_ip = 1'b0;
      if_req_ip = 1'b0;
      mem_rdata_ip = 32'h77777777;
      #2;
      rst_n_ip = 1'b0;
      #1;
      check("rst_seq async clear", all_out(), 160'(0));
      tick();
      rst_n_ip = 1'b1;
      tick();
      mem_rvalid_ip = 1'b1;
      #1;
      check("rst_seq stale rvalid", 160'({if_rvalid_op, ls_rvalid_op, if_rdata_op, ls_rdata_op}),
            160'(0));
      tick();
      mem_rvalid_ip = 1'b0;
      #1;
      check("rst_seq idle after stale", all_out(), 160'(0));
      tick();
      run_rows("after_rst", g6_lo, g6_hi);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
